matrix_mac_writeback: RTL and testbench

Arithmetic/write-back stage directly downstream of the matrix address sequencer. Takes the sequencer's run flag, end-of-dot-product marker (active-low `m_rst`) and target address. Consumes operand words returned by the first/second matrix memories, multiply-accumulates each dot product, and writes every finished result into the target matrix memory. Reports write count and a drain-complete pulse to the control path.

---
 rtl/matrix_mac_writeback.sv | 176 +++++++++++++++++
 tb/tb_matrix_mac_writeback.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_mac_writeback.sv
// Multiply-accumulate write-back stage behind the matrix address sequencer.
// Aligns sequencer control with returned operands, forms signed products,
// accumulates each dot product and writes the finished result to the target
// matrix memory. Reports write count, busy and a drain-complete pulse.
// Optional build macro MATRIX_MAC_SATURATE_EN: clamp the accumulator instead
// of letting it wrap.
module matrix_mac_writeback #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 20,
    parameter int unsigned ADR_W  = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_run,
    input  logic              i_last_n,
    input  logic [ADR_W-1:0]  i_t_adr,
    input  logic [DATA_W-1:0] i_fm_data,
    input  logic [DATA_W-1:0] i_sm_data,
    output logic              o_wr_en,
    output logic [ADR_W-1:0]  o_wr_adr,
    output logic [ACC_W-1:0]  o_wr_data,
    output logic [ADR_W:0]    o_wr_count,
    output logic              o_busy,
    output logic              o_done
);

    // Control word: {valid, last (active-high), address}
    localparam int unsigned CW = ADR_W + 2;

    logic [CW-1:0]        ctl_in;
    logic [RD_LAT*CW-1:0] al_q;
    logic [RD_LAT*CW-1:0] al_d;
    logic [CW-1:0]        al_out;

    assign ctl_in = {i_run, ~i_last_n, i_t_adr};
    // Newest word enters at the bottom; the oldest drops off the top.
    assign al_d   = (RD_LAT*CW)'({al_q, ctl_in});
    assign al_out = al_q[RD_LAT*CW-1 -: CW];

    // Align stage: delay control by the operand read latency
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            al_q <= '0;
        end else begin
            al_q <= al_d;
        end
    end

    logic signed [2*DATA_W-1:0] prod;
    logic                       mul_vld_q;
    logic                       mul_last_q;
    logic [ADR_W-1:0]           mul_adr_q;
    logic signed [ACC_W-1:0]    mul_prod_q;

    assign prod = $signed(i_fm_data) * $signed(i_sm_data);

    // Multiply stage: register sign-extended product with aligned control
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mul_vld_q  <= 1'b0;
            mul_last_q <= 1'b0;
            mul_adr_q  <= '0;
            mul_prod_q <= '0;
        end else begin
            mul_vld_q  <= al_out[CW-1];
            mul_last_q <= al_out[CW-2];
            mul_adr_q  <= al_out[ADR_W-1:0];
            mul_prod_q <= ACC_W'(prod);
        end
    end

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    first_q, first_d;
    logic                    acc_vld_q;
    logic signed [ACC_W-1:0] base;
    logic signed [ACC_W-1:0] sum;
    logic                    wr_en_d;
    logic [ADR_W-1:0]        wr_adr_d;
    logic [ACC_W-1:0]        wr_data_d;

`ifdef MATRIX_MAC_SATURATE_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    logic [ACC_W:0] wide;

    // Saturating add: one guard bit detects overflow, then clamp by its sign
    always_comb begin
        base = first_q ? '0 : acc_q;
        wide = {base[ACC_W-1], base} + {mul_prod_q[ACC_W-1], mul_prod_q};
        if (wide[ACC_W] != wide[ACC_W-1]) begin
            sum = wide[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            sum = wide[ACC_W-1:0];
        end
    end
`else
    // Wrapping add
    always_comb begin
        base = first_q ? '0 : acc_q;
        sum  = base + mul_prod_q;
    end
`endif

    // Accumulate next state: write on last term, discard a sum left without one
    always_comb begin
        acc_d     = acc_q;
        first_d   = first_q;
        wr_en_d   = 1'b0;
        wr_adr_d  = o_wr_adr;
        wr_data_d = o_wr_data;
        if (mul_vld_q) begin
            if (mul_last_q) begin
                wr_en_d   = 1'b1;
                wr_adr_d  = mul_adr_q;
                wr_data_d = sum;
                acc_d     = '0;
                first_d   = 1'b1;
            end else begin
                acc_d     = sum;
                first_d   = 1'b0;
            end
        end else if (acc_vld_q) begin
            // Term stream stopped without a last term
            acc_d   = '0;
            first_d = 1'b1;
        end
    end

    // Accumulate stage and write port registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_q     <= '0;
            first_q   <= 1'b1;
            acc_vld_q <= 1'b0;
            o_wr_en   <= 1'b0;
            o_wr_adr  <= '0;
            o_wr_data <= '0;
        end else begin
            acc_q     <= acc_d;
            first_q   <= first_d;
            acc_vld_q <= mul_vld_q;
            o_wr_en   <= wr_en_d;
            o_wr_adr  <= wr_adr_d;
            o_wr_data <= wr_data_d;
        end
    end

    logic run_q;
    logic busy_q;

    // Busy: any stage holding a valid term
    always_comb begin
        o_busy = mul_vld_q | acc_vld_q;
        for (int i = 0; i < int'(RD_LAT); i++) begin
            o_busy = o_busy | al_q[i*CW + CW - 1];
        end
    end

    // Drain complete: busy falling while the sequencer stays stopped
    assign o_done = busy_q & ~o_busy & ~i_run;

    // Write counter (restarts on run rising edge) and edge-history flops
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            run_q      <= 1'b0;
            busy_q     <= 1'b0;
            o_wr_count <= '0;
        end else begin
            run_q      <= i_run;
            busy_q     <= o_busy;
            o_wr_count <= ((i_run & ~run_q) ? '0 : o_wr_count) + (ADR_W+1)'(o_wr_en);
        end
    end

endmodule

// File: tb/tb_matrix_mac_writeback.sv
// Bench for matrix_mac_writeback: three instances (RD_LAT=1, RD_LAT=3, and a
// 16-bit accumulator) share one control stream; a dot-product level model
// predicts each write's cycle, address and data.
module tb_matrix_mac_writeback;

    typedef struct {
        int     cyc;
        int     adr;
        longint data;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run, last_n;
    logic [7:0] adr, a_op, b_op;
    logic [7:0] a_d1, b_d1;
    logic [7:0] a_d3 [3];
    logic [7:0] b_d3 [3];
    int         cyc = 0;

    logic [2:0]  wr_en, busy, done;
    logic [7:0]  wr_adr [3];
    logic [8:0]  cnt [3];
    logic [19:0] wd0, wd1;
    logic [15:0] wd2;

    int     n_cmp = 0;
    int     n_err = 0;
    int     done_cnt [3];
    int     done_base [3];
    int     exp_cnt = 0;
    bit     run_prev = 1'b0;
    longint prods [$];
    wr_t    expq [3][$];
    longint last_data16 = 0;
    int     lat [3]  = '{1, 3, 1};
    int     accw [3] = '{20, 20, 16};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Operand memories: return data RD_LAT cycles after the control word
    always @(posedge clk) begin
        a_d1    <= a_op;
        b_d1    <= b_op;
        a_d3[0] <= a_op;
        a_d3[1] <= a_d3[0];
        a_d3[2] <= a_d3[1];
        b_d3[0] <= b_op;
        b_d3[1] <= b_d3[0];
        b_d3[2] <= b_d3[1];
    end

    matrix_mac_writeback #(.DATA_W(8), .ACC_W(20), .ADR_W(8), .RD_LAT(1)) u_l1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_run(run), .i_last_n(last_n), .i_t_adr(adr),
        .i_fm_data(a_d1), .i_sm_data(b_d1), .o_wr_en(wr_en[0]), .o_wr_adr(wr_adr[0]),
        .o_wr_data(wd0), .o_wr_count(cnt[0]), .o_busy(busy[0]), .o_done(done[0])
    );

    matrix_mac_writeback #(.DATA_W(8), .ACC_W(20), .ADR_W(8), .RD_LAT(3)) u_l3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_run(run), .i_last_n(last_n), .i_t_adr(adr),
        .i_fm_data(a_d3[2]), .i_sm_data(b_d3[2]), .o_wr_en(wr_en[1]), .o_wr_adr(wr_adr[1]),
        .o_wr_data(wd1), .o_wr_count(cnt[1]), .o_busy(busy[1]), .o_done(done[1])
    );

    matrix_mac_writeback #(.DATA_W(8), .ACC_W(16), .ADR_W(8), .RD_LAT(1)) u_a16 (
        .i_clk(clk), .i_rst_n(rst_n), .i_run(run), .i_last_n(last_n), .i_t_adr(adr),
        .i_fm_data(a_d1), .i_sm_data(b_d1), .o_wr_en(wr_en[2]), .o_wr_adr(wr_adr[2]),
        .o_wr_data(wd2), .o_wr_count(cnt[2]), .o_busy(busy[2]), .o_done(done[2])
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reduce a running sum to an ACC_W-bit result (wrap, or clamp if built so)
    function automatic longint fold(input longint s, input int w);
        longint m, hi, lo, r;
        m  = longint'(1) << w;
        hi = (m >> 1) - 1;
        lo = -(m >> 1);
`ifdef MATRIX_MAC_SATURATE_EN
        r = s;
        if (r > hi) r = hi;
        if (r < lo) r = lo;
`else
        r = s & (m - 1);
        if (r > hi) r = r - m;
`endif
        return r;
    endfunction

    // Drive one control word (with its operands) and update the model
    task automatic step(input bit r, input bit l, input int ad, input int a, input int b);
        wr_t    e;
        longint s;
        @(negedge clk);
        run    = r;
        last_n = ~l;
        adr    = ad[7:0];
        a_op   = a[7:0];
        b_op   = b[7:0];
        if (r && !run_prev) exp_cnt = 0;
        run_prev = r;
        if (!r) begin
            prods.delete();
        end else begin
            prods.push_back(longint'(a) * longint'(b));
            if (l) begin
                for (int d = 0; d < 3; d++) begin
                    s = 0;
                    foreach (prods[k]) s = fold(s + prods[k], accw[d]);
                    e.cyc  = cyc + lat[d] + 2;
                    e.adr  = ad;
                    e.data = s;
                    expq[d].push_back(e);
                end
                prods.delete();
                exp_cnt++;
            end
        end
    endtask

    // Stop the run, wait (bounded) for drain, then check count/done/pending
    task automatic run_end(input string tag);
        int n;
        n = 0;
        step(0, 0, 0, 0, 0);
        while (busy != 3'b000 && n < 40) begin
            step(0, 0, 0, 0, 0);
            n++;
        end
        chk({tag, "_busy_after_drain"}, longint'(busy), 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s_wr_count[%0d]", tag, d), longint'(cnt[d]), exp_cnt % 512);
            chk($sformatf("%s_pending[%0d]", tag, d), expq[d].size(), 0);
            chk($sformatf("%s_done_pulses[%0d]", tag, d), done_cnt[d] - done_base[d], 1);
            done_base[d] = done_cnt[d];
        end
    endtask

    // Write monitor: every strobe must match the next predicted write
    always @(posedge clk) begin
        wr_t    e;
        longint dv [3];
        #1;
        dv[0] = longint'($signed(wd0));
        dv[1] = longint'($signed(wd1));
        dv[2] = longint'($signed(wd2));
        for (int d = 0; d < 3; d++) begin
            done_cnt[d] += int'(done[d]);
            while (expq[d].size() > 0 && expq[d][0].cyc < cyc) begin
                e = expq[d].pop_front();
                chk($sformatf("missed_write[%0d]", d), 0, 1);
            end
            if (rst_n && wr_en[d]) begin
                if (expq[d].size() == 0) begin
                    chk($sformatf("unexpected_write[%0d]", d), 1, 0);
                end else begin
                    e = expq[d].pop_front();
                    chk($sformatf("wr_cycle[%0d]", d), cyc, e.cyc);
                    chk($sformatf("wr_adr[%0d]", d), longint'(wr_adr[d]), e.adr);
                    chk($sformatf("wr_data[%0d]", d), dv[d], e.data);
                    if (d == 2) last_data16 = dv[2];
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int ma [2][2];
        int mb [2][2];
        int ndp, nt;
        ma = '{'{1, 2}, '{3, 4}};
        mb = '{'{5, 6}, '{7, 8}};
        for (int d = 0; d < 3; d++) begin
            done_cnt[d]  = 0;
            done_base[d] = 0;
        end
        rst_n = 1'b0;
        run = 1'b0; last_n = 1'b1; adr = '0; a_op = '0; b_op = '0;
        #2;
        chk("reset_wr_adr", longint'(wr_adr[0]), 0);
        chk("reset_wr_data", longint'(wd0), 0);
        chk("reset_done", longint'(done), 0);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset_wr_en[%0d]", d), longint'(wr_en[d]), 0);
            chk($sformatf("reset_busy[%0d]", d), longint'(busy[d]), 0);
            chk($sformatf("reset_count[%0d]", d), longint'(cnt[d]), 0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0);

        // 2x2 product, column-major issue order: writes 19, 43, 22, 50
        for (int j = 0; j < 2; j++)
            for (int i = 0; i < 2; i++)
                for (int k = 0; k < 2; k++)
                    step(1, k == 1, i * 2 + j, ma[i][k], mb[k][j]);
        run_end("mat2x2");

        // Signed operands: -3*5 + 2*(-7) = -29
        step(1, 0, 7, -3, 5);
        step(1, 1, 7, 2, -7);
        run_end("signed");

        // Three 127*127 terms: clamps to 32767 or wraps to -17149 at 16 bits
        step(1, 0, 9, 127, 127);
        step(1, 0, 9, 127, 127);
        step(1, 1, 9, 127, 127);
        run_end("overflow");
`ifdef MATRIX_MAC_SATURATE_EN
        chk("overflow_acc16", last_data16, 32767);
`else
        chk("overflow_acc16", last_data16, -17149);
`endif

        // Run dropped after 2 of 3 terms, then a fresh 4*5 must give 20
        step(1, 0, 3, 9, 9);
        step(1, 0, 3, 11, 13);
        step(0, 0, 0, 0, 0);
        step(1, 1, 4, 4, 5);
        run_end("abort");

        // Asynchronous reset mid-dot-product
        step(1, 1, 16, 2, 3);
        repeat (5) step(1, 0, 17, 1, 1);
        chk("prereset_busy", longint'(busy[0]), 1);
        chk("prereset_count", longint'(cnt[0]), 1);
        #2;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("midreset_wr_en[%0d]", d), longint'(wr_en[d]), 0);
            chk($sformatf("midreset_busy[%0d]", d), longint'(busy[d]), 0);
            chk($sformatf("midreset_count[%0d]", d), longint'(cnt[d]), 0);
            expq[d].delete();
        end
        prods.delete();
        run = 1'b0;
        run_prev = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int d = 0; d < 3; d++) done_base[d] = done_cnt[d];
        step(1, 1, 32, 6, 7);
        run_end("post_reset");

        // Back-to-back single-term dot products for 8 cycles
        for (int i = 0; i < 8; i++)
            step(1, 1, 40 + i, int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128);
        run_end("b2b");

        // Randomized runs; some end with a partial dot product that is discarded
        for (int r = 0; r < 20; r++) begin
            ndp = int'($urandom_range(4, 1));
            for (int p = 0; p < ndp; p++) begin
                nt = int'($urandom_range(4, 1));
                for (int t = 0; t < nt; t++)
                    step(1, t == nt - 1, int'($urandom_range(255)),
                         int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128);
            end
            if ($urandom_range(4) == 0) begin
                nt = int'($urandom_range(2, 1));
                for (int t = 0; t < nt; t++)
                    step(1, 0, 5, int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128);
            end
            run_end($sformatf("rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
